mult_share_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for one shared signed 8x8 add-shift multiplier core.
- Latches a requester's operands and drives the core's load/run sequence.
- Waits for the core's Done, then returns the 16-bit product, or an error on timeout, to the owning requester.
- Sits between the lab datapath clients and the multiplier core. No client touches the core's S/LoadB/Run directly.

---
 rtl/mult_share_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one signed 8x8 add-shift multiplier core between two requesters.
// Gnt one cycle after Req is sampled in IDLE, Done the cycle after M_Done; MULT_ARB_PERF_EN adds op/error counters.
module mult_share_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int CW      = 7
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic [7:0]  OpA0,
  input  logic [7:0]  OpA1,
  input  logic [7:0]  OpB0,
  input  logic [7:0]  OpB1,
  output logic        Gnt0,
  output logic        Gnt1,
  output logic        Done0,
  output logic        Done1,
  output logic        Err0,
  output logic        Err1,
  output logic [15:0] Prod0,
  output logic [15:0] Prod1,
  output logic        Busy,
  output logic [7:0]  M_S,
  output logic        M_LoadB,
  output logic        M_Run,
  output logic        M_Clear,
  input  logic        M_Done,
  input  logic [15:0] M_Product
`ifdef MULT_ARB_PERF_EN
  ,
  output logic [15:0] OpCnt0,
  output logic [15:0] OpCnt1,
  output logic [7:0]  ErrCnt
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SETUP = 3'd3;
  localparam logic [2:0] S_RUN   = 3'd4;
  localparam logic [2:0] S_WAIT  = 3'd5;
  localparam logic [2:0] S_RESP  = 3'd6;
  localparam logic [2:0] S_ABORT = 3'd7;

  logic [2:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic          owner_q, owner_d;
  logic [7:0]    opa_q, opa_d;
  logic [7:0]    opb_q, opb_d;
  logic [15:0]   prod0_q, prod0_d;
  logic [15:0]   prod1_q, prod1_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    prod0_d = prod0_q;
    prod1_d = prod1_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (Req0 || Req1) begin
          // rr pointer only matters on a tie; a lone requester always wins
          owner_d = (Req0 && Req1) ? rr_q : Req1;
          opa_d   = owner_d ? OpA1 : OpA0;
          opb_d   = owner_d ? OpB1 : OpB0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: state_d = S_LOAD;
      S_LOAD:  state_d = S_SETUP;
      S_SETUP: state_d = S_RUN;
      S_RUN: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Done takes priority over a timeout landing on the same edge
        if (M_Done) begin
          if (owner_q) prod1_d = M_Product;
          else         prod0_d = M_Product;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP, S_ABORT: begin
        rr_d    = ~owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      prod0_q <= '0;
      prod1_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      prod0_q <= prod0_d;
      prod1_q <= prod1_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    M_S = 8'h00;
    case (state_q)
      S_LOAD:                M_S = opb_q;
      S_SETUP, S_RUN, S_WAIT: M_S = opa_q;
      default:               M_S = 8'h00;
    endcase
  end

  assign Gnt0    = (state_q == S_GRANT) && !owner_q;
  assign Gnt1    = (state_q == S_GRANT) &&  owner_q;
  assign Done0   = (state_q == S_RESP)  && !owner_q;
  assign Done1   = (state_q == S_RESP)  &&  owner_q;
  assign Err0    = (state_q == S_ABORT) && !owner_q;
  assign Err1    = (state_q == S_ABORT) &&  owner_q;
  assign M_LoadB = (state_q == S_LOAD);
  assign M_Run   = (state_q == S_RUN);
  assign M_Clear = (state_q == S_ABORT);
  assign Busy    = (state_q != S_IDLE);
  assign Prod0   = prod0_q;
  assign Prod1   = prod1_q;

`ifdef MULT_ARB_PERF_EN
  logic [15:0] opcnt0_q, opcnt1_q;
  logic [7:0]  errcnt_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      opcnt0_q <= '0;
      opcnt1_q <= '0;
      errcnt_q <= '0;
    end else begin
      if (Done0 && (opcnt0_q != 16'hFFFF)) opcnt0_q <= opcnt0_q + 16'd1;
      if (Done1 && (opcnt1_q != 16'hFFFF)) opcnt1_q <= opcnt1_q + 16'd1;
      if ((state_q == S_ABORT) && (errcnt_q != 8'hFF)) errcnt_q <= errcnt_q + 8'd1;
    end
  end

  assign OpCnt0 = opcnt0_q;
  assign OpCnt1 = opcnt1_q;
  assign ErrCnt = errcnt_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: core model (Done 20 cycles after Run), per-transaction reference model,
// directed literal scenarios and randomized two-requester traffic.
module tb_mult_share_arbiter;
  localparam int TIMEOUT  = 64;
  localparam int CORE_LAT = 20;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic [7:0]  OpA0 = '0, OpA1 = '0, OpB0 = '0, OpB1 = '0;
  logic        Gnt0, Gnt1, Done0, Done1, Err0, Err1, Busy;
  logic [15:0] Prod0, Prod1;
  logic [7:0]  M_S;
  logic        M_LoadB, M_Run, M_Clear;
  logic        M_Done = 1'b0;
  logic [15:0] M_Product = '0;
`ifdef MULT_ARB_PERF_EN
  logic [15:0] OpCnt0, OpCnt1;
  logic [7:0]  ErrCnt;
`endif

  mult_share_arbiter #(.TIMEOUT(TIMEOUT), .CW(7)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .OpA0(OpA0), .OpA1(OpA1), .OpB0(OpB0), .OpB1(OpB1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .Done0(Done0), .Done1(Done1), .Err0(Err0), .Err1(Err1),
    .Prod0(Prod0), .Prod1(Prod1), .Busy(Busy),
    .M_S(M_S), .M_LoadB(M_LoadB), .M_Run(M_Run), .M_Clear(M_Clear),
    .M_Done(M_Done), .M_Product(M_Product)
`ifdef MULT_ARB_PERF_EN
    , .OpCnt0(OpCnt0), .OpCnt1(OpCnt1), .ErrCnt(ErrCnt)
`endif
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Core model: captures B on LoadB, A on Run, raises Done CORE_LAT cycles later (unless hung)
  logic [7:0] core_a = '0, core_b = '0;
  int         core_cnt = 0;
  bit         core_done = 1'b0;
  bit         core_hang = 1'b0;
  int         hang_mode = 0;   // 0 never hang, 1 always hang, 2 hang at random

  task automatic tick();
    @(negedge Clk);
    cyc++;
    if (M_LoadB) begin core_b = M_S; core_done = 1'b0; core_cnt = 0; end
    if (M_Clear) begin core_done = 1'b0; core_cnt = 0; end
    if (M_Run) begin
      core_a    = M_S;
      core_cnt  = CORE_LAT;
      core_done = 1'b0;
      core_hang = (hang_mode == 1) || (hang_mode == 2 && $urandom_range(15) == 0);
    end else if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0 && !core_hang) begin
        core_done = 1'b1;
        M_Product = {{8{core_a[7]}}, core_a} * {{8{core_b[7]}}, core_b};
      end
    end
    M_Done = core_done;
  endtask

  // Reference model: one transaction at a time, tracked by cycles elapsed since its grant
  bit          m_busy = 1'b0;
  bit          m_own = 1'b0;
  bit          m_pref = 1'b0;
  int          m_t = 0;
  int          m_end = 0;       // 0 in flight, 1 completing, 2 timing out
  logic [7:0]  m_a = '0, m_b = '0;
  logic [15:0] m_prod [2];
  int          m_opcnt [2];
  int          m_errcnt = 0;

  always @(posedge Clk) begin
    if (!Reset) begin
      m_busy = 1'b0; m_pref = 1'b0; m_t = 0; m_end = 0; m_own = 1'b0;
      m_a = '0; m_b = '0;
      m_prod[0] = '0; m_prod[1] = '0;
      m_opcnt[0] = 0; m_opcnt[1] = 0; m_errcnt = 0;
    end else if (m_busy) begin
      if (m_end != 0) begin
        if (m_end == 1 && m_opcnt[m_own] < 65535) m_opcnt[m_own]++;
        if (m_end == 2 && m_errcnt < 255) m_errcnt++;
        m_busy = 1'b0;
        m_pref = !m_own;
      end else if (m_t >= 4 && M_Done) begin
        m_end = 1;
        m_prod[m_own] = M_Product;
      end else if (m_t - 4 == TIMEOUT - 1) begin
        m_end = 2;
      end else begin
        m_t++;
      end
    end else if (Req0 || Req1) begin
      if (Req0 && Req1) m_own = m_pref;
      else              m_own = Req1;
      m_a = m_own ? OpA1 : OpA0;
      m_b = m_own ? OpB1 : OpB0;
      m_busy = 1'b1; m_t = 0; m_end = 0;
    end
  end

  always @(negedge Clk) begin
    logic [9:0] exp_p, act_p;
    if (chk_en) begin
      exp_p = {m_busy && m_end == 0 && m_t == 0 && !m_own, m_busy && m_end == 0 && m_t == 0 && m_own,
               m_busy && m_end == 1 && !m_own, m_busy && m_end == 1 && m_own,
               m_busy && m_end == 2 && !m_own, m_busy && m_end == 2 && m_own,
               m_busy && m_end == 0 && m_t == 1, m_busy && m_end == 0 && m_t == 3,
               m_busy && m_end == 2, m_busy};
      act_p = {Gnt0, Gnt1, Done0, Done1, Err0, Err1, M_LoadB, M_Run, M_Clear, Busy};
      check("cyc_pulses", 32'(act_p), 32'(exp_p));
      check("cyc_prods", {Prod0, Prod1}, {m_prod[0], m_prod[1]});
      if (!m_busy) check("cyc_ms_idle", 32'(M_S), 32'd0);
      else if (m_end == 0 && m_t >= 1) check("cyc_ms", 32'(M_S), 32'(m_t == 1 ? m_b : m_a));
`ifdef MULT_ARB_PERF_EN
      check("cyc_opcnt", {OpCnt0, OpCnt1}, {16'(m_opcnt[0]), 16'(m_opcnt[1])});
      check("cyc_errcnt", 32'(ErrCnt), 32'(m_errcnt));
`endif
    end
  end

  function automatic bit sig(input int code);
    case (code)
      0: return Gnt0;
      1: return Gnt1;
      2: return Done0;
      3: return Done1;
      4: return Err0;
      5: return Err1;
      6: return M_Run;
      7: return Done0 | Err0;
      8: return Done1 | Err1;
      default: return !Busy;
    endcase
  endfunction

  task automatic wait_for(input int code, input int limit, input string name, output int at);
    int n = 0;
    while (!sig(code) && n < limit) begin tick(); n++; end
    check({name, "_seen"}, 32'(sig(code)), 32'd1);
    at = cyc;
  endtask

  task automatic do_reset();
    Reset = 1'b0; Req0 = 1'b0; Req1 = 1'b0;
    tick();
    Reset = 1'b1;
    core_cnt = 0; core_done = 1'b0; M_Done = 1'b0;
  endtask

  task automatic do_op(input bit who, input logic [7:0] a, input logic [7:0] b);
    int g, e;
    if (who) begin Req1 = 1'b1; OpA1 = a; OpB1 = b; end
    else     begin Req0 = 1'b1; OpA0 = a; OpB0 = b; end
    wait_for(who ? 1 : 0, 200, "op_gnt", g);
    if (who) Req1 = 1'b0; else Req0 = 1'b0;
    wait_for(who ? 8 : 7, 200, "op_end", e);
  endtask

  initial begin
    int r, d, e, g, d0, g1, busy_at, pulses;
    logic [15:0] p0;
    int order [$];

    tick();
    chk_en = 1'b1;
    Reset = 1'b1;
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_prods", {Prod0, Prod1}, 32'd0);
    check("rst_ms", 32'(M_S), 32'd0);
    check("rst_pulses", 32'({Gnt0, Gnt1, Done0, Done1, Err0, Err1, M_LoadB, M_Run, M_Clear}), 32'd0);

    // 3 x 5 on requester 0, step by step
    Req0 = 1'b1; OpA0 = 8'h03; OpB0 = 8'h05;
    tick();
    check("t1_gnt0", 32'(Gnt0), 32'd1);
    check("t1_gnt1", 32'(Gnt1), 32'd0);
    Req0 = 1'b0;
    tick();
    check("t1_loadb", 32'({M_LoadB, M_S}), 32'h105);
    tick();
    check("t1_setup", 32'({M_Run, M_S}), 32'h003);
    tick();
    check("t1_run", 32'({M_Run, M_S}), 32'h103);
    r = cyc;
    wait_for(2, 100, "t1_done0", d);
    check("t1_done_lat", 32'(d - r), 32'd21);
    check("t1_prod0", 32'(Prod0), 32'h000F);
    check("t1_prod1", 32'(Prod1), 32'h0000);

    // -2 x 7 on requester 1
    do_op(1'b1, 8'hFE, 8'h07);
    check("t2_done1", 32'({Done1, Err1}), 32'h2);
    check("t2_prod1", 32'(Prod1), 32'hFFF2);
    check("t2_prod0", 32'(Prod0), 32'h000F);

    // simultaneous requests held: alternate 0,1,0,1
    do_reset();
    Req0 = 1'b1; Req1 = 1'b1; OpA0 = 8'h02; OpB0 = 8'h09; OpA1 = 8'h81; OpB1 = 8'h03;
    d0 = -1; g1 = -1;
    for (int i = 0; i < 500 && order.size() < 4; i++) begin
      tick();
      if (Gnt0) order.push_back(0);
      if (Gnt1) begin order.push_back(1); if (g1 < 0) g1 = cyc; end
      if (Done0 && d0 < 0) d0 = cyc;
    end
    Req0 = 1'b0; Req1 = 1'b0;
    check("t3_ngrants", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) check("t3_order", 32'(order[i]), 32'(i % 2));
    check("t3_gnt1_after_done0", 32'(g1 - d0), 32'd2);
    wait_for(9, 100, "t3_idle", busy_at);

    // timeout on requester 0
    hang_mode = 1;
    p0 = Prod0;
    Req0 = 1'b1; OpA0 = 8'h11; OpB0 = 8'h22;
    wait_for(0, 20, "t4_gnt0", g);
    Req0 = 1'b0;
    wait_for(6, 20, "t4_run", r);
    wait_for(4, 200, "t4_err0", e);
    check("t4_err_lat", 32'(e - r), 32'd65);
    check("t4_clear", 32'({M_Clear, Done0}), 32'h2);
    check("t4_prod0", 32'(Prod0), 32'(p0));
    hang_mode = 0;
    tick();
    check("t4_idle", 32'(Busy), 32'd0);
    Req0 = 1'b1; Req1 = 1'b1; OpA1 = 8'h04; OpB1 = 8'h04;
    tick();
    check("t4_next_gnt", 32'({Gnt0, Gnt1}), 32'h1);
    Req1 = 1'b0;
    wait_for(0, 100, "t4_gnt0_later", g);
    Req0 = 1'b0;
    wait_for(2, 100, "t4_done0_later", d);

    // reset in the middle of WAIT
    tick();
    Req0 = 1'b1; OpA0 = 8'h05; OpB0 = 8'h06;
    wait_for(0, 20, "t5_gnt0", g);
    Req0 = 1'b0;
    wait_for(6, 20, "t5_run", r);
    for (int i = 0; i < 5; i++) tick();
    do_reset();
    check("t5_busy", 32'(Busy), 32'd0);
    check("t5_prods", {Prod0, Prod1}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (Done0 || Done1 || Err0 || Err1) pulses++;
    end
    check("t5_no_pulse", 32'(pulses), 32'd0);

    // three completions and one timeout on requester 0 (signed corner operands)
    do_op(1'b0, 8'h7F, 8'h7F);
    check("t6_prod_a", 32'(Prod0), 32'h3F01);
    do_op(1'b0, 8'h80, 8'h80);
    check("t6_prod_b", 32'(Prod0), 32'h4000);
    do_op(1'b0, 8'h80, 8'h7F);
    check("t6_prod_c", 32'(Prod0), 32'hC080);
    hang_mode = 1;
    do_op(1'b0, 8'hFF, 8'h01);
    hang_mode = 0;
    check("t6_err0", 32'(Err0), 32'd1);
    tick();
    check("t6_prod_kept", 32'(Prod0), 32'hC080);
`ifdef MULT_ARB_PERF_EN
    check("t6_opcnt0", 32'(OpCnt0), 32'd3);
    check("t6_opcnt1", 32'(OpCnt1), 32'd0);
    check("t6_errcnt", 32'(ErrCnt), 32'd1);
`endif

    // random traffic, occasional core hangs
    hang_mode = 2;
    for (int c = 0; c < 3000; c++) begin
      if (Gnt0) begin Req0 = ($urandom_range(1) == 1); OpA0 = 8'($urandom); OpB0 = 8'($urandom); end
      else if (!Req0 && $urandom_range(3) == 0) begin Req0 = 1'b1; OpA0 = 8'($urandom); OpB0 = 8'($urandom); end
      if (Gnt1) begin Req1 = ($urandom_range(1) == 1); OpA1 = 8'($urandom); OpB1 = 8'($urandom); end
      else if (!Req1 && $urandom_range(3) == 0) begin Req1 = 1'b1; OpA1 = 8'($urandom); OpB1 = 8'($urandom); end
      tick();
    end
    hang_mode = 0;
    while ((Req0 || Req1) && !Busy) tick();
    Req0 = 1'b0; Req1 = 1'b0;
    wait_for(9, 200, "end_idle", busy_at);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
